// File: rtl/pb_varint_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pb_varint_stream_decoder
// Purpose  : Streaming decoder for protobuf base-128 varints. Takes one byte
//            per cycle on a valid/ready byte stream. Emits one decoded value
//            per varint on a valid/ready result port. Optionally splits keys
//            into field number / wire type and flags malformed encodings.
// Optional : define PB_VARINT_ZIGZAG_EN to add zigzag (sint) decoding.
// Ports    :
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     byte handshake; in_data[7] is the continuation bit
//   key_mode              sampled with the first byte; 1 = decode as key
//   zigzag                (PB_VARINT_ZIGZAG_EN) sampled with the first byte
//   out_valid/out_ready   result handshake
//   out_value             decoded value
//   out_field/out_wire    out_value>>3 / out_value[2:0] (key mode)
//   out_is_key            latched key_mode
//   out_is_zigzag         (PB_VARINT_ZIGZAG_EN) zigzag applied to out_value
//   out_err               [0] overlong, [1] overflow, [2] bad wire type
// Revision : 1.0 - initial release
// ============================================================================
module pb_varint_stream_decoder #(
  parameter int VALUE_W   = 64,
  parameter int MAX_BYTES = (VALUE_W + 6) / 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               key_mode,
`ifdef PB_VARINT_ZIGZAG_EN
  input  logic               zigzag,
  output logic               out_is_zigzag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VALUE_W-1:0] out_value,
  output logic [VALUE_W-4:0] out_field,
  output logic [2:0]         out_wire,
  output logic               out_is_key,
  output logic [2:0]         out_err
);

  localparam int CNT_W  = $clog2(MAX_BYTES + 1);
  // Wide enough to hold the last payload group at its full shift, so the
  // bits that fall off the top of VALUE_W can be inspected for overflow.
  localparam int WIDE_W = 7 * MAX_BYTES + 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [VALUE_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 key_q, key_d;
  logic                 drain_q, drain_d;
  logic [VALUE_W-1:0]   out_value_q, out_value_d;
  logic [2:0]           out_err_q, out_err_d;
  logic                 out_is_key_q, out_is_key_d;
`ifdef PB_VARINT_ZIGZAG_EN
  logic                 zz_q, zz_d;
  logic                 out_is_zz_q, out_is_zz_d;
  logic                 zz_new;
`endif

  logic                 accept;
  logic                 first_byte;
  logic                 term;
  logic                 overlong;
  logic                 finish;
  logic [15:0]          shamt;
  logic [WIDE_W-1:0]    byte_wide;
  logic [WIDE_W-1:0]    shifted;
  logic                 dropped;
  logic [VALUE_W-1:0]   acc_base;
  logic [VALUE_W-1:0]   acc_new;
  logic                 ovf_new;
  logic                 key_new;
  logic [VALUE_W-1:0]   value_new;

  // --------------------------------------------------------------------------
  // Datapath: merge the current byte into the accumulator
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready   = (state_q != ST_HOLD);
    out_valid  = (state_q == ST_HOLD);
    accept     = in_valid & in_ready;
    first_byte = (state_q == ST_IDLE);
    term       = ~in_data[7];

    // cnt_q is 0 in IDLE, so the first byte lands unshifted.
    shamt     = 16'(cnt_q) * 16'd7;
    byte_wide = {{(WIDE_W-7){1'b0}}, in_data[6:0]};
    shifted   = byte_wide << shamt;
    dropped   = |shifted[WIDE_W-1:VALUE_W];

    acc_base = first_byte ? '0 : acc_q;
    acc_new  = acc_base | shifted[VALUE_W-1:0];
    ovf_new  = (ovf_q & ~first_byte) | dropped;
    key_new  = first_byte ? key_mode : key_q;

    // Continuation still set on the last legal byte: stop and drain the rest.
    overlong = (state_q == ST_ACCUM) && in_data[7] &&
               (cnt_q == CNT_W'(MAX_BYTES - 1));

    finish = accept && ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) &&
             (term || overlong);

`ifdef PB_VARINT_ZIGZAG_EN
    // Zigzag only applies to plain values; keys are always unsigned.
    zz_new    = first_byte ? (zigzag & ~key_mode) : zz_q;
    value_new = zz_new ? ((acc_new >> 1) ^ {VALUE_W{acc_new[0]}}) : acc_new;
`else
    value_new = acc_new;
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state and output register updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    key_d        = key_q;
    drain_d      = drain_q;
    out_value_d  = out_value_q;
    out_err_d    = out_err_q;
    out_is_key_d = out_is_key_q;
`ifdef PB_VARINT_ZIGZAG_EN
    zz_d         = zz_q;
    out_is_zz_d  = out_is_zz_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = acc_new;
          cnt_d   = CNT_W'(1);
          ovf_d   = ovf_new;
          key_d   = key_mode;
          drain_d = 1'b0;
`ifdef PB_VARINT_ZIGZAG_EN
          zz_d    = zz_new;
`endif
          state_d = term ? ST_HOLD : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_new;
          if (term) begin
            state_d = ST_HOLD;
          end else if (overlong) begin
            state_d = ST_HOLD;
            drain_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
          drain_d = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Tail of an overlong varint: swallow bytes up to its terminator.
        if (accept && term) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are captured once, on the transition into HOLD, so they stay
    // stable for the whole time the result waits on out_ready.
    if (finish) begin
      out_value_d  = value_new;
      out_err_d    = {key_new && (acc_new[2:1] == 2'b11), ovf_new, overlong};
      out_is_key_d = key_new;
`ifdef PB_VARINT_ZIGZAG_EN
      out_is_zz_d  = zz_new;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      key_q        <= 1'b0;
      drain_q      <= 1'b0;
      out_value_q  <= '0;
      out_err_q    <= '0;
      out_is_key_q <= 1'b0;
`ifdef PB_VARINT_ZIGZAG_EN
      zz_q         <= 1'b0;
      out_is_zz_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      key_q        <= key_d;
      drain_q      <= drain_d;
      out_value_q  <= out_value_d;
      out_err_q    <= out_err_d;
      out_is_key_q <= out_is_key_d;
`ifdef PB_VARINT_ZIGZAG_EN
      zz_q         <= zz_d;
      out_is_zz_q  <= out_is_zz_d;
`endif
    end
  end

  assign out_value  = out_value_q;
  assign out_field  = out_value_q[VALUE_W-1:3];
  assign out_wire   = out_value_q[2:0];
  assign out_is_key = out_is_key_q;
  assign out_err    = out_err_q;
`ifdef PB_VARINT_ZIGZAG_EN
  assign out_is_zigzag = out_is_zz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pb_varint_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_varint_stream_decoder
// Purpose  : Self-checking bench for pb_varint_stream_decoder (VALUE_W=64).
//            Expected results are queued when a varint is sent and compared
//            when the decoder hands a result over. Zigzag cases are compiled
//            in when PB_VARINT_ZIGZAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_varint_stream_decoder;

  localparam int VW = 64;

  typedef struct packed {
    logic [63:0] v;
    logic [2:0]  e;
    logic        k;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          key_mode;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_value;
  logic [VW-4:0] out_field;
  logic [2:0]    out_wire;
  logic          out_is_key;
  logic [2:0]    out_err;
`ifdef PB_VARINT_ZIGZAG_EN
  logic          zigzag;
  logic          out_is_zigzag;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  pb_varint_stream_decoder #(.VALUE_W(VW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .key_mode   (key_mode),
`ifdef PB_VARINT_ZIGZAG_EN
    .zigzag       (zigzag),
    .out_is_zigzag(out_is_zigzag),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_field  (out_field),
    .out_wire   (out_wire),
    .out_is_key (out_is_key),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a result is consumed when valid&ready is seen mid-cycle,
  // i.e. the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_value", out_value, e.v);
        check("out_err", 64'(out_err), 64'(e.e));
        check("out_is_key", 64'(out_is_key), 64'(e.k));
        if (e.k) begin
          check("out_field", 64'(out_field), e.v >> 3);
          check("out_wire", 64'(out_wire), 64'(e.v[2:0]));
        end
      end
    end
  end

  // Present one byte and return at posedge+1 of the cycle it was accepted.
  task automatic send(input logic [7:0] b, input logic k, input logic z);
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    key_mode = k;
`ifdef PB_VARINT_ZIGZAG_EN
    zigzag   = z;
`else
    if (z) in_data = b;
`endif
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_bad++;
        $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    key_mode  = 1'b0;
    out_ready = 1'b1;
`ifdef PB_VARINT_ZIGZAG_EN
    zigzag    = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_out_is_key", 64'(out_is_key), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-byte varint 150 and its latency
    sb.push_back('{v: 64'd150, e: 3'b000, k: 1'b0});
    send(8'h96, 1'b0, 1'b0);
    check("lat_mid_out_valid", 64'(out_valid), 64'd0);
    send(8'h01, 1'b0, 1'b0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_in_ready_hold", 64'(in_ready), 64'd0);
    check("lat_out_value", out_value, 64'd150);
    wait_empty();

    // Key mode, including bad wire types and a multi-byte key
    sb.push_back('{v: 64'd8,   e: 3'b000, k: 1'b1});
    send(8'h08, 1'b1, 1'b0);
    sb.push_back('{v: 64'd15,  e: 3'b100, k: 1'b1});
    send(8'h0F, 1'b1, 1'b0);
    sb.push_back('{v: 64'd14,  e: 3'b100, k: 1'b1});
    send(8'h0E, 1'b1, 1'b0);
    sb.push_back('{v: 64'd150, e: 3'b100, k: 1'b1});
    send(8'h96, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    wait_empty();

    // Full-width value, then the same with a bit pushed past bit 63
    sb.push_back('{v: 64'hFFFF_FFFF_FFFF_FFFF, e: 3'b000, k: 1'b0});
    repeat (9) send(8'hFF, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    wait_empty();
    sb.push_back('{v: 64'h7FFF_FFFF_FFFF_FFFF, e: 3'b010, k: 1'b0});
    repeat (9) send(8'hFF, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    wait_empty();

    // Overlong: ten continuation bytes end the varint, the tail is drained
    sb.push_back('{v: 64'd0, e: 3'b001, k: 1'b0});
    sb.push_back('{v: 64'd5, e: 3'b000, k: 1'b0});
    repeat (11) send(8'h80, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check("drain_no_output", 64'(out_valid), 64'd0);
    send(8'h05, 1'b0, 1'b0);
    wait_empty();

    // Backpressure: result held, next byte stalled until handshake
    out_ready = 1'b0;
    sb.push_back('{v: 64'd150, e: 3'b000, k: 1'b0});
    sb.push_back('{v: 64'd42,  e: 3'b000, k: 1'b0});
    send(8'h96, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h2A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_value", out_value, 64'd150);
    end
    out_ready = 1'b1;
    send(8'h2A, 1'b0, 1'b0);
    wait_empty();

    // Reset in the middle of a varint drops the partial value
    send(8'hAC, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef PB_VARINT_ZIGZAG_EN
    sb.push_back('{v: 64'hFFFF_FFFF_FFFF_FFFE, e: 3'b000, k: 1'b0});
    send(8'h03, 1'b0, 1'b1);
    check("zz_out_is_zigzag", 64'(out_is_zigzag), 64'd1);
    wait_empty();
    sb.push_back('{v: 64'd8, e: 3'b000, k: 1'b1});
    send(8'h08, 1'b1, 1'b1);
    check("zz_key_ignored", 64'(out_is_zigzag), 64'd0);
    wait_empty();
`else
    sb.push_back('{v: 64'd3, e: 3'b000, k: 1'b0});
    send(8'h03, 1'b0, 1'b1);
    wait_empty();
`endif

    repeat (4) @(posedge clk);
    #1;
    check("final_scoreboard", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pb_varint_stream_decoder.md
Name: pb_varint_stream_decoder

Overview:
- Synthesizable streaming decoder for protobuf base-128 varints.
- Consumes one byte per cycle on a valid/ready byte stream and emits one decoded value per varint on a valid/ready output.
- Optionally splits message keys into field number and wire type, and flags malformed encodings.
- Sits between the byte-stream ingress and the message field dispatcher in the hardware protobuf path.

Parameters:
- VALUE_W, 64, width of the decoded value; legal range 8..64.
- MAX_BYTES, (VALUE_W+6)/7, maximum encoded bytes per varint; 10 when VALUE_W=64.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  input byte accepted when in_valid and in_ready are both high
- in_data  input  8  encoded byte; bit 7 is the continuation bit
- key_mode  input  1  sampled with the first byte of each varint; 1 means decode as a message key
- out_valid  output  1  decoded result valid
- out_ready  input  1  downstream accepts the result
- out_value  output  VALUE_W  decoded value
- out_field  output  VALUE_W-3  out_value>>3; meaningful only in key mode
- out_wire  output  3  out_value[2:0]; meaningful only in key mode
- out_is_key  output  1  latched key_mode
- out_err  output  3  error flags: [0] overlong, [1] overflow, [2] bad wire type

Behaviour:
- Reset (async assert, sync deassert)
  - state=IDLE; out_valid=0; out_value, out_err and out_is_key=0; byte counter=0; accumulator=0.
  - in_ready is 1 after reset.
- FSM states: IDLE, ACCUM, HOLD, DRAIN.
  - IDLE: on accepting byte b:
    - acc = b[6:0]; cnt = 1; is_key = key_mode.
    - If b[7]=0, go to HOLD; otherwise go to ACCUM.
  - ACCUM: on accepting byte k (0-based):
    - acc |= b[6:0] << 7k; bits at or above VALUE_W are dropped.
    - If any dropped bit is nonzero, set err[1].
    - If b[7]=0, go to HOLD.
    - Else if k+1 == MAX_BYTES, set err[0] and go to HOLD with drain_pending=1.
  - HOLD:
    - out_valid=1 and in_ready=0.
    - On out_valid & out_ready: go to DRAIN if drain_pending, otherwise to IDLE.
  - DRAIN:
    - in_ready=1; accepted bytes are discarded and produce no output.
    - The first byte with b[7]=0 is discarded, then the FSM goes to IDLE.
- Latency: out_valid rises the cycle after the terminating byte is accepted.
  - Single-byte varints run at one result per 2 cycles when out_ready=1.
  - n-byte varints take n+1 cycles.
- Output registers are stable while out_valid & !out_ready.
- Key mode: err[2] is set when out_wire is 6 or 7. Multiple err bits may be set at once.
- Bytes with in_valid=0 do not advance the FSM. In IDLE, ACCUM and DRAIN, in_ready is not gated by in_valid.
- Reset asserted mid-varint discards the partial value; no output is produced for it.

Optional Feature:
- Macro PB_VARINT_ZIGZAG_EN.
- Enabled:
  - Adds input port zigzag (1 bit), sampled with the first byte alongside key_mode.
  - Adds output out_is_zigzag.
  - When set and key_mode=0, out_value = (acc>>1) ^ -(acc[0]), computed at the HOLD transition.
  - When key_mode=1, zigzag is ignored.
- Disabled: neither port exists and out_value is always the raw accumulator.

Test Plan:
- Bytes 0x96,0x01, key_mode=0 -> out_value=150, out_err=0, out_valid on cycle 3 after the first accept.
- Byte 0x08, key_mode=1 -> out_value=8, out_field=1, out_wire=0. Byte 0x0F -> out_wire=7, out_err=3'b100.
- VALUE_W=64 input:
  - 9×0xFF then 0x01 -> out_value=0xFFFF_FFFF_FFFF_FFFF, err=0.
  - Final byte 0x02 instead -> err[1]=1 and bit 64 is dropped.
- Eleven 0x80 bytes then 0x00, then 0x05:
  - First result has err=3'b001.
  - The 11th byte and 0x00 are drained.
  - Next result is 5 with err=0.
- Backpressure: hold out_ready=0 for 5 cycles during 0x96,0x01,0x2A -> in_ready=0, out_value stays 150; after the handshake, 42 is delivered.
- Reset pulse after accepting 0xAC -> out_valid=0 and in_ready=1. Then 0x03 with zigzag=1 (macro on) -> out_value=-2 (0xFFFF_FFFF_FFFF_FFFE).
